// File: rtl/nes_joypad_pkg.sv
// Shared constants and helpers for the NES joypad bank.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package nes_joypad_pkg;

    // CPU addresses of the joypad registers; port p sits at JOY1_ADDR + p.
    localparam logic [15:0] JOY1_ADDR = 16'h4016;
    localparam logic [15:0] JOY2_ADDR = 16'h4017;

    // Button order within a serial report; bit 0 leaves the shifter first.
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // CPU data bus width.
    localparam int DATA_W = 8;

    // Read data layout: upper bits come from open bus, bit 0 is the serial bit.
    typedef struct packed {
        logic [DATA_W-1:1] open_bus;
        logic              serial;
    } rd_dat_t;

    // Width of a saturating read counter that must reach shift_w.
    function automatic int cnt_w(input int shift_w);
        return $clog2(shift_w) + 1;
    endfunction

    // Width of the port select; never narrower than one bit.
    function automatic int sel_w(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/nes_joypad_shifter.sv
// One joypad serial shift register with a saturating read counter.
// Latency: load/shift take effect at the next clk edge; q0 is the current LSB.
// Backpressure: none; load has priority over shift, reset over both.
module nes_joypad_shifter
    import nes_joypad_pkg::*;
#(
    parameter int   SHIFT_W  = 8,
    parameter logic FILL_BIT = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load,
    input  logic                        shift,
    input  logic [SHIFT_W-1:0]          din,
    output logic                        q0,
    output logic [cnt_w(SHIFT_W)-1:0]   count
);

    localparam int              CNT_W   = cnt_w(SHIFT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SHIFT_W);

    logic [SHIFT_W-1:0] sr;
    logic [SHIFT_W-1:0] shifted;

    // A one-bit report degenerates to "replace with fill"; wider reports
    // move towards bit 0 and pull the fill bit in at the top.
    generate
        if (SHIFT_W > 1) begin : g_wide
            assign shifted = {FILL_BIT, sr[SHIFT_W-1:1]};
        end else begin : g_narrow
            assign shifted = FILL_BIT;
        end
    endgenerate

    // Shift register: parallel load while strobed, otherwise one shift per read.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= shifted;
        end
    end

    // Read counter: cleared by load, saturates once the whole report is out.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (shift && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign q0 = sr[0];

endmodule

// File: rtl/nes_joypad_bank.sv
// Bank of NES serial joypad ports at $4016+p with a NIOS-fed keycode holding register.
// Latency: read edge -> data_out in 1 cycle; keys_load -> data_out via strobe reload in <= 3 cycles.
// Backpressure: none; every rden rising edge is one access, a held rden is ignored after the edge.
module nes_joypad_bank
    import nes_joypad_pkg::*;
#(
    parameter int         NUM_PORTS     = 2,
    parameter int         SHIFT_W       = 8,
    parameter logic       FILL_BIT      = 1'b1,
    parameter logic [7:0] OPEN_BUS_MASK = 8'hE0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 rden,
    input  logic                                 wren,
    input  logic [sel_w(NUM_PORTS)-1:0]          port_sel,
    input  logic [7:0]                           data_in,
    input  logic [7:0]                           open_bus_in,
    input  logic [NUM_PORTS*SHIFT_W-1:0]         keys_in,
    input  logic                                 keys_load,
    output logic [7:0]                           data_out,
    output logic                                 strobe,
    output logic [NUM_PORTS*cnt_w(SHIFT_W)-1:0]  rd_count
);

    localparam int SEL_W = sel_w(NUM_PORTS);
    localparam int CNT_W = cnt_w(SHIFT_W);

    logic                         rden_q;
    logic                         read_edge;
    logic [NUM_PORTS*SHIFT_W-1:0] hold;
    logic [NUM_PORTS-1:0]         q0;
    logic [NUM_PORTS-1:0]         shift;
    logic                         sel_bit;
    rd_dat_t                      rd_next;

    // Only bit 0 of the write data and bits 7:1 of open bus are meaningful.
    logic unused_bits;
    assign unused_bits = ^{data_in[7:1], open_bus_in[0]};

    // A CPU access may hold rden for several cycles; only the first counts.
    assign read_edge = rden && !rden_q;

    // Read strobe edge detector; cleared by reset so a held rden re-triggers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rden_q <= 1'b0;
        end else begin
            rden_q <= rden;
        end
    end

    // Strobe register; writes to the other offsets belong to the APU frame counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            strobe <= 1'b0;
        end else if (wren && (port_sel == '0)) begin
            strobe <= data_in[0];
        end
    end

    // Holding register: all ports captured together so a report is never torn.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold <= '0;
        end else if (keys_load) begin
            hold <= keys_in;
        end
    end

    // Per-port shifters; reads use the pre-write strobe, so a strobe high
    // in this cycle reloads instead of shifting.
    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            assign shift[p] = read_edge && !strobe && (port_sel == SEL_W'(p));

            nes_joypad_shifter #(
                .SHIFT_W  (SHIFT_W),
                .FILL_BIT (FILL_BIT)
            ) u_shifter (
                .clk   (clk),
                .reset (reset),
                .load  (strobe),
                .shift (shift[p]),
                .din   (hold[p*SHIFT_W +: SHIFT_W]),
                .q0    (q0[p]),
                .count (rd_count[p*CNT_W +: CNT_W])
            );
        end
    endgenerate

    // Serial bit for the selected port: live A button while strobed, else the
    // shifter LSB; an unpopulated port reads 0.
    always_comb begin
        sel_bit = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (int'(port_sel) == p) begin
                sel_bit = strobe ? hold[p*SHIFT_W] : q0[p];
            end
        end
    end

    // Upper bits float on the real console; unmasked ones read as 0.
    always_comb begin
        rd_next          = '0;
        rd_next.open_bus = open_bus_in[7:1] & OPEN_BUS_MASK[7:1];
        rd_next.serial   = sel_bit;
    end

    // Read data register: updated once per access and held until the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
        end else if (read_edge) begin
            data_out <= rd_next;
        end
    end

endmodule

// File: tb/tb_nes_joypad_bank.sv
module tb_nes_joypad_bank;

    localparam int NUM_PORTS = 2;
    localparam int SHIFT_W   = 8;
    localparam int CNT_W     = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        rden;
    logic        wren;
    logic [0:0]  port_sel;
    logic [7:0]  data_in;
    logic [7:0]  open_bus_in;
    logic [15:0] keys_in;
    logic        keys_load;
    logic [7:0]  data_out;
    logic        strobe;
    logic [7:0]  rd_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nes_joypad_bank #(
        .NUM_PORTS     (NUM_PORTS),
        .SHIFT_W       (SHIFT_W),
        .FILL_BIT      (1'b1),
        .OPEN_BUS_MASK (8'hE0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rden        (rden),
        .wren        (wren),
        .port_sel    (port_sel),
        .data_in     (data_in),
        .open_bus_in (open_bus_in),
        .keys_in     (keys_in),
        .keys_load   (keys_load),
        .data_out    (data_out),
        .strobe      (strobe),
        .rd_count    (rd_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [0:0] sel, input logic [7:0] d);
        port_sel = sel;
        data_in  = d;
        wren     = 1'b1;
        step();
        wren     = 1'b0;
    endtask

    task automatic load_keys(input logic [7:0] k0, input logic [7:0] k1);
        keys_in   = {k1, k0};
        keys_load = 1'b1;
        step();
        keys_load = 1'b0;
    endtask

    task automatic strobe_pulse();
        write_reg(1'b0, 8'h01);
        write_reg(1'b0, 8'h00);
    endtask

    // Single-cycle access; returns data_out as seen right after the edge.
    task automatic do_read(input logic [0:0] sel, output logic [7:0] d);
        port_sel = sel;
        rden     = 1'b1;
        step();
        d        = data_out;
        rden     = 1'b0;
        step();
    endtask

    function automatic logic [3:0] cnt(input int p);
        return rd_count[p*CNT_W +: CNT_W];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int seq1 [10] = '{1, 0, 1, 0, 0, 0, 0, 1, 1, 1};

        reset       = 1'b1;
        rden        = 1'b0;
        wren        = 1'b0;
        port_sel    = 1'b0;
        data_in     = 8'h00;
        open_bus_in = 8'h00;
        keys_in     = 16'h0000;
        keys_load   = 1'b0;
        step();
        step();
        check("reset data_out", data_out, 8'h00);
        check("reset strobe", strobe, 1'b0);
        check("reset rd_count", rd_count, 8'h00);
        reset = 1'b0;
        step();

        // Full report readout on port 0, then fill bits and saturation.
        load_keys(8'b1000_0101, 8'h00);
        write_reg(1'b0, 8'h01);
        check("s1 strobe set", strobe, 1'b1);
        write_reg(1'b0, 8'h00);
        check("s1 strobe clear", strobe, 1'b0);
        for (int i = 0; i < 10; i++) begin
            do_read(1'b0, d);
            check($sformatf("s1 read%0d bit", i), d[0], seq1[i]);
            check($sformatf("s1 read%0d cnt", i), cnt(0), (i < 8) ? i + 1 : 8);
        end

        // Held rden on port 1: one shift only.
        load_keys(8'h00, 8'h02);
        strobe_pulse();
        check("s2 port0 cnt reload", cnt(0), 4'd0);
        port_sel = 1'b1;
        rden     = 1'b1;
        repeat (5) step();
        d        = data_out;
        rden     = 1'b0;
        step();
        check("s2 held read bit", d[0], 1'b0);
        check("s2 held read cnt", cnt(1), 4'd1);
        do_read(1'b1, d);
        check("s2 second read bit", d[0], 1'b1);
        check("s2 second read cnt", cnt(1), 4'd2);

        // Reads while strobed return the live A button.
        load_keys(8'h01, 8'h02);
        write_reg(1'b0, 8'h01);
        for (int i = 0; i < 3; i++) begin
            do_read(1'b0, d);
            check($sformatf("s3 strobed read%0d bit", i), d[0], 1'b1);
            check($sformatf("s3 strobed read%0d cnt", i), cnt(0), 4'd0);
        end
        load_keys(8'h00, 8'h02);
        do_read(1'b0, d);
        check("s3 live update bit", d[0], 1'b0);
        write_reg(1'b0, 8'h00);

        // keys_load mid-report leaves the current report intact.
        load_keys(8'hFF, 8'h02);
        strobe_pulse();
        for (int i = 0; i < 3; i++) begin
            do_read(1'b0, d);
            check($sformatf("s4 pre-load read%0d", i), d[0], 1'b1);
        end
        load_keys(8'h00, 8'h02);
        for (int i = 0; i < 5; i++) begin
            do_read(1'b0, d);
            check($sformatf("s4 post-load read%0d", i), d[0], 1'b1);
        end
        strobe_pulse();
        do_read(1'b0, d);
        check("s4 restrobe read", d[0], 1'b0);

        // Open-bus bits and port isolation.
        open_bus_in = 8'hFF;
        do_read(1'b0, d);
        check("s5 open bus FF", d, 8'hE0);
        open_bus_in = 8'h55;
        do_read(1'b1, d);
        check("s5 open bus 55 p1 r0", d, 8'h40);
        do_read(1'b1, d);
        check("s5 open bus 55 p1 r1", d, 8'h41);
        check("s5 port0 cnt untouched", cnt(0), 4'd2);
        check("s5 port1 cnt", cnt(1), 4'd2);
        write_reg(1'b1, 8'h01);
        check("s5 frame counter write ignored", strobe, 1'b0);

        // Read edge coincident with a strobe write.
        open_bus_in = 8'h00;
        load_keys(8'b0000_0110, 8'h02);
        strobe_pulse();
        do_read(1'b0, d);
        check("s6 first read", d[0], 1'b0);
        port_sel = 1'b0;
        data_in  = 8'h01;
        rden     = 1'b1;
        wren     = 1'b1;
        step();
        d        = data_out;
        rden     = 1'b0;
        wren     = 1'b0;
        check("s6 coincident bit", d[0], 1'b1);
        check("s6 coincident cnt", cnt(0), 4'd2);
        check("s6 coincident strobe", strobe, 1'b1);
        step();
        check("s6 reload after strobe", cnt(0), 4'd0);
        write_reg(1'b0, 8'h00);
        do_read(1'b0, d);
        check("s6 reread bit0", d[0], 1'b0);
        do_read(1'b0, d);
        check("s6 reread bit1", d[0], 1'b1);

        // Reset mid-report with rden held through it.
        open_bus_in = 8'hFF;
        write_reg(1'b0, 8'h01);
        port_sel = 1'b0;
        rden     = 1'b1;
        reset    = 1'b1;
        step();
        check("s6 reset data_out", data_out, 8'h00);
        check("s6 reset strobe", strobe, 1'b0);
        check("s6 reset rd_count", rd_count, 8'h00);
        reset = 1'b0;
        step();
        check("s6 post-reset edge data", data_out, 8'hE0);
        check("s6 post-reset edge cnt", cnt(0), 4'd1);
        rden = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
